// File: rtl/mem_select_arbiter.sv
// Arbitrated N-way memory read select with a single-entry output register.
// Channel choice is round-robin or fixed priority. Downstream drains the register via valid/ready.
module mem_select_arbiter #(
  parameter  int WIDTH   = 16,
  parameter  int NUM_IN  = 4,
  parameter  int RR_MODE = 1,
  localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] memin,
  input  logic [NUM_IN-1:0]       memreq,
  output logic [NUM_IN-1:0]       memack,
  output logic [WIDTH-1:0]        dataout,
  output logic                    dataout_valid,
  input  logic                    dataout_ready,
  output logic [SEL_W-1:0]        dataout_src
);

  logic [SEL_W-1:0] r_last;
  logic [SEL_W-1:0] r_src;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [SEL_W-1:0] w_cand;
  logic [SEL_W-1:0] w_win;
  logic             w_found;
  logic             w_cap;
  logic [WIDTH-1:0] w_sel_data;

  // Winner search: scan starts one past the last grant (round-robin) or at index 0 (fixed).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (RR_MODE != 0) begin
        w_cand = SEL_W'((int'(r_last) + 1 + k) % NUM_IN);
      end else begin
        w_cand = SEL_W'(k);
      end
      if (!w_found && memreq[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // No acknowledge may escape while reset is held, even with requests pending.
  assign w_cap      = (|memreq) && (!r_valid || dataout_ready) && !reset;
  assign w_sel_data = memin[w_win*WIDTH +: WIDTH];
  assign memack     = w_cap ? (NUM_IN'(1) << w_win) : '0;

  // Output register: capture on grant, drop valid on a drain with nothing to replace it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last  <= SEL_W'(NUM_IN - 1);
      r_src   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_last  <= w_win;
      r_src   <= w_win;
      r_data  <= w_sel_data;
      r_valid <= 1'b1;
    end else if (r_valid && dataout_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign dataout       = r_data;
  assign dataout_valid = r_valid;
  assign dataout_src   = r_src;

endmodule

// File: tb/tb_mem_select_arbiter.sv
// Scoreboard bench for mem_select_arbiter: one round-robin and one fixed-priority instance share stimulus.
module tb_mem_select_arbiter;
  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic [SEL_W-1:0] src;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] memin;
  logic [NUM_IN-1:0]       memreq;
  logic                    dataout_ready;
  logic [WIDTH-1:0]        ch [NUM_IN];

  logic [NUM_IN-1:0] memack, memack_fp;
  logic [WIDTH-1:0]  dataout, dataout_fp;
  logic              dataout_valid, dataout_valid_fp;
  logic [SEL_W-1:0]  dataout_src, dataout_src_fp;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int               m_last;
  bit               m_valid, m_valid_fp;
  logic [WIDTH-1:0] m_data, m_data_fp;
  int               m_src, m_src_fp;

  always #5 clk = ~clk;

  always_comb begin
    memin = '0;
    for (int i = 0; i < NUM_IN; i++) memin[i*WIDTH +: WIDTH] = ch[i];
  end

  mem_select_arbiter #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .memin(memin), .memreq(memreq), .memack(memack),
    .dataout(dataout), .dataout_valid(dataout_valid), .dataout_ready(dataout_ready),
    .dataout_src(dataout_src));

  mem_select_arbiter #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .memin(memin), .memreq(memreq), .memack(memack_fp),
    .dataout(dataout_fp), .dataout_valid(dataout_valid_fp), .dataout_ready(dataout_ready),
    .dataout_src(dataout_src_fp));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_IN-1:0] req, input int last, input bit rr);
    int c;
    for (int k = 1; k <= NUM_IN; k++) begin
      c = rr ? (last + k) % NUM_IN : k - 1;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q_rr.delete();
    q_fp.delete();
    m_last = NUM_IN - 1;
    m_valid = 1'b0; m_valid_fp = 1'b0;
    m_data = '0; m_data_fp = '0;
    m_src = 0; m_src_fp = 0;
  endtask

  // One clock: check acknowledges mid-cycle, push predictions, then check registers after the edge.
  task automatic step();
    int w, wf;
    bit cap, capf;
    exp_t e;
    @(negedge clk);
    cap  = (|memreq) && (!m_valid || dataout_ready);
    capf = (|memreq) && (!m_valid_fp || dataout_ready);
    w  = pick(memreq, m_last, 1'b1);
    wf = pick(memreq, 0, 1'b0);
    check("rr_memack", 32'(memack), cap ? (32'd1 << w) : 32'd0);
    check("fp_memack", 32'(memack_fp), capf ? (32'd1 << wf) : 32'd0);
    if (cap) begin
      e.src = w[SEL_W-1:0]; e.data = ch[w];
      q_rr.push_back(e);
    end
    if (capf) begin
      e.src = wf[SEL_W-1:0]; e.data = ch[wf];
      q_fp.push_back(e);
    end
    @(posedge clk);
    #1;
    if (cap) begin
      e = q_rr.pop_front();
      m_data = e.data; m_src = int'(e.src); m_valid = 1'b1; m_last = w;
    end else if (m_valid && dataout_ready) begin
      m_valid = 1'b0;
    end
    if (capf) begin
      e = q_fp.pop_front();
      m_data_fp = e.data; m_src_fp = int'(e.src); m_valid_fp = 1'b1;
    end else if (m_valid_fp && dataout_ready) begin
      m_valid_fp = 1'b0;
    end
    check("rr_dataout", 32'(dataout), 32'(m_data));
    check("rr_src", 32'(dataout_src), 32'(m_src));
    check("rr_valid", 32'(dataout_valid), 32'(m_valid));
    check("fp_dataout", 32'(dataout_fp), 32'(m_data_fp));
    check("fp_src", 32'(dataout_src_fp), 32'(m_src_fp));
    check("fp_valid", 32'(dataout_valid_fp), 32'(m_valid_fp));
  endtask

  logic [WIDTH-1:0] rr_seq [5];

  initial begin
    rr_seq[0] = 16'h1000; rr_seq[1] = 16'h1001; rr_seq[2] = 16'h1002;
    rr_seq[3] = 16'h1003; rr_seq[4] = 16'h1000;
    reset = 1'b1;
    memreq = 4'b0000;
    dataout_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) ch[i] = 16'h0000;
    model_reset();

    // Reset held with every channel requesting
    repeat (2) @(posedge clk);
    #1 memreq = 4'b1111;
    #2;
    check("rst_dataout", 32'(dataout), 32'h0);
    check("rst_valid", 32'(dataout_valid), 32'h0);
    check("rst_memack", 32'(memack), 32'h0);
    check("rst_memack_fp", 32'(memack_fp), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    memreq = 4'b0000;
    repeat (5) step();

    // Round-robin fairness, all channels requesting
    for (int i = 0; i < NUM_IN; i++) ch[i] = 16'h1000 + 16'(i);
    memreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq", 32'(dataout), 32'(rr_seq[i]));
    end
    step();

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(dataout_valid), 32'h0);
    check("async_memack", 32'(memack), 32'h0);
    check("async_valid_fp", 32'(dataout_valid_fp), 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("post_rst_src", 32'(dataout_src), 32'h0);
    check("post_rst_data", 32'(dataout), 32'h1000);
    memreq = 4'b0000;
    step();

    // Single request, one-cycle latency
    ch[2] = 16'hBEEF;
    memreq = 4'b0100;
    step();
    check("single_data", 32'(dataout), 32'hBEEF);
    check("single_src", 32'(dataout_src), 32'h2);
    check("single_valid", 32'(dataout_valid), 32'h1);
    memreq = 4'b0000;
    step();

    // Fixed priority on the second instance
    memreq = 4'b1010;
    repeat (3) begin
      step();
      check("fp_src_hold", 32'(dataout_src_fp), 32'h1);
    end
    memreq = 4'b0000;
    step();

    // Backpressure
    ch[3] = 16'h00AA;
    memreq = 4'b1000;
    step();
    check("bp_capture", 32'(dataout), 32'h00AA);
    ch[0] = 16'h5555;
    memreq = 4'b0001;
    dataout_ready = 1'b0;
    repeat (4) begin
      step();
      check("bp_hold", 32'(dataout), 32'h00AA);
    end
    dataout_ready = 1'b1;
    step();
    check("bp_release_data", 32'(dataout), 32'h5555);
    check("bp_release_src", 32'(dataout_src), 32'h0);
    memreq = 4'b0000;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
